lw_hmac_key_loader: RTL

//  Key staging buffer directly upstream of the HMAC engine's key port. Host writes up to
//  one block of key words; on arm, streams exactly BLOCK_WORDS words (key words, then

---
 rtl/lw_sha_pkg.sv | 5 +
 rtl/lw_hmac_key_loader.sv | 84 ++++++++
 2 files changed

// File: rtl/lw_sha_pkg.sv
// lw_sha_pkg: shared types and constants for the lightweight SHA/HMAC blocks
package lw_sha_pkg;
  localparam int KEY_BLOCK_WORDS = 16;
  typedef enum logic [1:0] {KL_IDLE, KL_STREAM, KL_WIPE} key_ld_state_t;
endpackage

// File: rtl/lw_hmac_key_loader.sv
// lw_hmac_key_loader: stages one block of key words and streams it, zero-padded, into the HMAC key port
module lw_hmac_key_loader
  import lw_sha_pkg::*;
#(
  parameter int WORD_W      = 64,
  parameter int BLOCK_WORDS = KEY_BLOCK_WORDS,
  parameter int KEEP_KEY    = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [3:0]        wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [4:0]        key_len_i,
  input  logic              arm_i,
  input  logic              zeroize_i,
  input  logic              abort_i,
  output logic [WORD_W-1:0] key_o,
  output logic              key_valid_o,
  input  logic              key_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam logic [3:0] LAST    = 4'(BLOCK_WORDS - 1);
  localparam logic [4:0] MAX_LEN = 5'(BLOCK_WORDS);
  key_ld_state_t     state_q;
  logic [3:0]        idx_q;
  logic [4:0]        len_q;
  logic              done_q;
  logic              err_q;
  logic [WORD_W-1:0] key_buf [BLOCK_WORDS];
  // words past the latched length are streamed as zero padding
  always_comb begin
    key_valid_o = state_q == KL_STREAM;
    busy_o      = state_q != KL_IDLE;
    done_o      = done_q;
    err_o       = err_q;
    key_o       = (key_valid_o && {1'b0, idx_q} < len_q) ? key_buf[idx_q] : '0;
  end
  // control FSM; idx doubles as stream pointer and descending wipe pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= KL_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) key_buf[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == KL_IDLE) begin
        if (zeroize_i) begin
          state_q <= KL_WIPE;
          idx_q   <= LAST;
        end else begin
          if (wr_en_i) key_buf[wr_addr_i] <= wr_data_i;
          if (arm_i && key_len_i > MAX_LEN) err_q <= 1'b1;
          else if (arm_i) begin
            len_q   <= key_len_i;
            idx_q   <= '0;
            err_q   <= 1'b0;
            state_q <= KL_STREAM;
          end
        end
      end else if (state_q == KL_STREAM) begin
        if (abort_i) begin
          state_q <= KL_WIPE;
          idx_q   <= LAST;
        end else if (key_ready_i) begin
          if (idx_q == LAST) begin
            done_q  <= 1'b1;
            state_q <= (KEEP_KEY != 0) ? KL_IDLE : KL_WIPE;
            idx_q   <= (KEEP_KEY != 0) ? 4'd0 : LAST;
          end else idx_q <= idx_q + 4'd1;
        end
      end else begin
        key_buf[idx_q] <= '0;
        if (idx_q == 4'd0) state_q <= KL_IDLE;
        else idx_q <= idx_q - 4'd1;
      end
    end
  end
endmodule
